// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, line idle level and parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_e;

    // Level of an idle serial line (mark).
    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Widest payload any UART block in this layer supports.
    localparam int UART_MAX_DATA_BITS = 9;

    // Parity bit a transmitter sends for a payload. Narrower payloads are
    // zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic uart_parity(input logic [UART_MAX_DATA_BITS-1:0] data,
                                         input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-stage synchronizer for an asynchronous input pin, reset to a chosen level.
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic stage1_q;
    logic stage2_q;

    // Shift the pin through two flops so downstream logic sees a settled level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage1_q <= RESET_VAL;
            stage2_q <= RESET_VAL;
        end else begin
            stage1_q <= d;
            stage2_q <= stage1_q;
        end
    end

    assign q = stage2_q;

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receive engine with a valid/ready holding register.
module uart_receiver #(
    parameter int DATA_BITS  = 8,
    parameter int SAMPLE     = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sample_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    import uart_pkg::*;

    localparam int CNT_W = $clog2(SAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(SAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(SAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic HAS_PARITY = (PARITY_EN != 0);
    localparam logic ODD_PARITY = (PARITY_ODD != 0);

    logic rx_s;
    logic rx_q;
    logic fall_edge;
    logic start_seen;
    logic deliver;
    logic handshake;
    logic [UART_MAX_DATA_BITS-1:0] shift_ext;

    uart_rx_state_e state_q, state_d;
    logic [CNT_W-1:0]     tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_err_q, par_err_d;
    logic                 edge_pend_q, edge_pend_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overrun_q, overrun_d;

    uart_rx_sync #(
        .RESET_VAL (UART_IDLE_LEVEL)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rx),
        .q       (rx_s)
    );

    // A falling edge lasts one clk at rx_s/rx_q, while ticks are sparser, so the
    // edge is remembered until the next tick as long as the line stays low.
    assign fall_edge  = rx_q & ~rx_s;
    assign start_seen = (edge_pend_q | fall_edge) & ~rx_s;
    assign handshake  = rx_valid_q & rx_ready;
    assign shift_ext  = UART_MAX_DATA_BITS'(shift_q);

    // Frame sequencing: every counter and state change is gated by sample_tick.
    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_err_d   = par_err_q;
        edge_pend_d = (edge_pend_q | fall_edge) & ~rx_s;
        deliver     = 1'b0;

        if (sample_tick) begin
            edge_pend_d = 1'b0;
            tick_cnt_d  = tick_cnt_q + CNT_W'(1);
            case (state_q)
                IDLE: begin
                    tick_cnt_d = '0;
                    if (start_seen) begin
                        state_d = START;
                    end
                end
                START: begin
                    if (tick_cnt_q == HALF_LAST) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = rx_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (tick_cnt_q == FULL_LAST) begin
                        tick_cnt_d = '0;
                        shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d  = bit_cnt_q + BIT_W'(1);
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = HAS_PARITY ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (tick_cnt_q == FULL_LAST) begin
                        tick_cnt_d = '0;
                        par_err_d  = rx_s ^ uart_parity(shift_ext, ODD_PARITY);
                        state_d    = STOP;
                    end
                end
                STOP: begin
                    if (tick_cnt_q == FULL_LAST) begin
                        tick_cnt_d = '0;
                        deliver    = 1'b1;
                        state_d    = IDLE;
                    end
                end
                default: begin
                    tick_cnt_d = '0;
                    state_d    = IDLE;
                end
            endcase
        end
    end

    // Holding register: load a finished frame when empty or being drained, else flag overrun.
    always_comb begin
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        overrun_d    = 1'b0;

        if (deliver) begin
            if (!rx_valid_q || handshake) begin
                rx_data_d    = shift_q;
                rx_valid_d   = 1'b1;
                frame_err_d  = ~rx_s;
                parity_err_d = HAS_PARITY & par_err_q;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (handshake) begin
            rx_valid_d = 1'b0;
        end
    end

    // Register all state; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_q         <= UART_IDLE_LEVEL;
            state_q      <= IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_err_q    <= 1'b0;
            edge_pend_q  <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_q         <= rx_s;
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_err_q    <= par_err_d;
            edge_pend_q  <= edge_pend_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: one plain instance and one with even parity.
module tb_uart_receiver;

    localparam int SAMPLE   = 16;
    localparam int TICK_DIV = 4;
    localparam int BIT_CLK  = SAMPLE * TICK_DIV;

    typedef struct packed {
        logic [7:0] data;
        logic       fe;
        logic       pe;
    } rx_item_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sample_tick = 1'b0;
    logic       rx0 = 1'b1;
    logic       rx1 = 1'b1;
    logic       ready0 = 1'b0;
    logic       ready1 = 1'b0;
    logic [7:0] data0, data1;
    logic       valid0, valid1, fe0, fe1, pe0, pe1, ovr0, ovr1;

    int tests_run = 0;
    int tests_failed = 0;
    int tdiv = 0;
    int valid_cycles0 = 0;
    int ovr_cnt0 = 0;
    int ovr_cnt1 = 0;
    rx_item_t got0[$];
    rx_item_t got1[$];

    uart_receiver #(
        .DATA_BITS (8), .SAMPLE (SAMPLE), .PARITY_EN (0), .PARITY_ODD (0)
    ) dut0 (
        .clk (clk), .reset_n (reset_n), .sample_tick (sample_tick), .rx (rx0),
        .rx_data (data0), .rx_valid (valid0), .rx_ready (ready0),
        .frame_err (fe0), .parity_err (pe0), .overrun (ovr0)
    );

    uart_receiver #(
        .DATA_BITS (8), .SAMPLE (SAMPLE), .PARITY_EN (1), .PARITY_ODD (0)
    ) dut1 (
        .clk (clk), .reset_n (reset_n), .sample_tick (sample_tick), .rx (rx1),
        .rx_data (data1), .rx_valid (valid1), .rx_ready (ready1),
        .frame_err (fe1), .parity_err (pe1), .overrun (ovr1)
    );

    always #5 clk = ~clk;

    // Tick generator: one-clk pulse every TICK_DIV clocks, driven away from the active edge.
    always @(negedge clk) begin
        tdiv = (tdiv + 1) % TICK_DIV;
        sample_tick = (tdiv == 0);
    end

    // Monitor: record every accepted byte, valid-high cycles and overrun pulses.
    always @(negedge clk) begin
        if (reset_n) begin
            if (valid0) valid_cycles0++;
            if (valid0 && ready0) got0.push_back('{data0, fe0, pe0});
            if (valid1 && ready1) got1.push_back('{data1, fe1, pe1});
            if (ovr0) ovr_cnt0++;
            if (ovr1) ovr_cnt1++;
        end
    end

    // Even/odd parity error as seen by a receiver: total ones of data plus parity bit.
    function automatic logic model_parity_err(input logic [7:0] d, input logic par_bit, input logic odd);
        int ones;
        ones = $countones(d) + int'(par_bit);
        return (ones % 2) != (odd ? 1 : 0);
    endfunction

    task automatic drive_bit(input int which, input logic b);
        @(negedge clk);
        if (which == 0) rx0 = b; else rx1 = b;
        repeat (BIT_CLK - 1) @(negedge clk);
    endtask

    task automatic send_frame(input int which, input logic [7:0] d, input logic stop_b,
                              input logic use_par, input logic par_b);
        drive_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
        if (use_par) drive_bit(which, par_b);
        drive_bit(which, stop_b);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({data0, valid0, fe0, pe0, ovr0} !== 12'h000) begin
            tests_failed++;
            $display("[TB] FAIL reset_dut0: got %h expected 000", {data0, valid0, fe0, pe0, ovr0});
        end
        tests_run++;
        if ({data1, valid1, fe1, pe1, ovr1} !== 12'h000) begin
            tests_failed++;
            $display("[TB] FAIL reset_dut1: got %h expected 000", {data1, valid1, fe1, pe1, ovr1});
        end
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_frame_a5();
        int vc;
        ready0 = 1'b1;
        got0.delete();
        vc = valid_cycles0;
        send_frame(0, 8'hA5, 1'b1, 1'b0, 1'b0);
        drive_bit(0, 1'b1);
        tests_run++;
        if (got0.size() != 1) begin
            tests_failed++;
            $display("[TB] FAIL a5_count: got %0d frames expected 1", got0.size());
        end else begin
            tests_run++;
            if (got0[0] !== rx_item_t'{8'hA5, 1'b0, 1'b0}) begin
                tests_failed++;
                $display("[TB] FAIL a5_frame: got %h expected %h", got0[0], rx_item_t'{8'hA5, 1'b0, 1'b0});
            end
        end
        tests_run++;
        if (valid_cycles0 - vc != 1) begin
            tests_failed++;
            $display("[TB] FAIL a5_valid_width: got %0d cycles expected 1", valid_cycles0 - vc);
        end
    endtask

    task automatic test_glitch();
        got0.delete();
        @(negedge clk);
        rx0 = 1'b0;
        repeat (3 * TICK_DIV - 1) @(negedge clk);
        rx0 = 1'b1;
        repeat (11 * BIT_CLK) @(negedge clk);
        tests_run++;
        if (got0.size() != 0 || valid0 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL glitch: got %0d frames valid=%b expected 0 frames valid=0", got0.size(), valid0);
        end
    endtask

    task automatic test_break();
        ready0 = 1'b1;
        got0.delete();
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        drive_bit(0, 1'b1);
        @(negedge clk);
        rx0 = 1'b0;
        repeat (2 * 10 * BIT_CLK) @(negedge clk);
        tests_run++;
        if (got0.size() != 2) begin
            tests_failed++;
            $display("[TB] FAIL break_count: got %0d frames expected 2", got0.size());
        end else begin
            tests_run++;
            if (got0[0] !== rx_item_t'{8'h3C, 1'b1, 1'b0}) begin
                tests_failed++;
                $display("[TB] FAIL break_3c: got %h expected %h", got0[0], rx_item_t'{8'h3C, 1'b1, 1'b0});
            end
            tests_run++;
            if (got0[1] !== rx_item_t'{8'h00, 1'b1, 1'b0}) begin
                tests_failed++;
                $display("[TB] FAIL break_00: got %h expected %h", got0[1], rx_item_t'{8'h00, 1'b1, 1'b0});
            end
        end
        rx0 = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        tests_run++;
        if (got0.size() != 2) begin
            tests_failed++;
            $display("[TB] FAIL break_release: got %0d frames expected 2", got0.size());
        end
    endtask

    task automatic test_parity();
        rx_item_t exp;
        ready1 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            logic pb;
            pb = (k == 0);
            got1.delete();
            send_frame(1, 8'h07, 1'b1, 1'b1, pb);
            drive_bit(1, 1'b1);
            exp = '{8'h07, 1'b0, model_parity_err(8'h07, pb, 1'b0)};
            tests_run++;
            if (got1.size() != 1) begin
                tests_failed++;
                $display("[TB] FAIL parity_count_%0d: got %0d frames expected 1", k, got1.size());
            end else begin
                tests_run++;
                if (got1[0] !== exp) begin
                    tests_failed++;
                    $display("[TB] FAIL parity_frame_%0d: got %h expected %h", k, got1[0], exp);
                end
            end
        end
    endtask

    task automatic test_overrun();
        int oc;
        ready0 = 1'b0;
        oc = ovr_cnt0;
        send_frame(0, 8'h11, 1'b1, 1'b0, 1'b0);
        drive_bit(0, 1'b1);
        send_frame(0, 8'h22, 1'b1, 1'b0, 1'b0);
        drive_bit(0, 1'b1);
        tests_run++;
        if (ovr_cnt0 - oc != 1 || data0 !== 8'h11 || valid0 !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL overrun_hold: got ovr=%0d data=%h valid=%b expected ovr=1 data=11 valid=1",
                     ovr_cnt0 - oc, data0, valid0);
        end
        // Third frame: raise ready exactly in the delivery cycle (152 ticks after detection).
        fork
            send_frame(0, 8'h33, 1'b1, 1'b0, 1'b0);
            begin
                @(negedge clk);
                repeat (2) @(posedge clk);
                @(posedge clk);
                while (!sample_tick) @(posedge clk);
                for (int t = 0; t < SAMPLE / 2 + 9 * SAMPLE - 1; t++) begin
                    @(posedge clk);
                    while (!sample_tick) @(posedge clk);
                end
                repeat (TICK_DIV) @(negedge clk);
                ready0 = 1'b1;
                @(posedge clk);
                @(negedge clk);
                tests_run++;
                if (valid0 !== 1'b1 || data0 !== 8'h33 || fe0 !== 1'b0 || ovr_cnt0 - oc != 1) begin
                    tests_failed++;
                    $display("[TB] FAIL overrun_replace: got valid=%b data=%h fe=%b ovr=%0d expected 1 33 0 1",
                             valid0, data0, fe0, ovr_cnt0 - oc);
                end
                ready0 = 1'b0;
            end
        join
        drive_bit(0, 1'b1);
        ready0 = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (valid0 !== 1'b0 || data0 !== 8'h33) begin
            tests_failed++;
            $display("[TB] FAIL overrun_drain: got valid=%b data=%h expected 0 33", valid0, data0);
        end
    endtask

    task automatic test_random();
        rx_item_t exp0[$];
        rx_item_t exp1[$];
        ready0 = 1'b1;
        ready1 = 1'b1;
        got0.delete();
        got1.delete();
        for (int n = 0; n < 8; n++) begin
            logic [7:0] d0, d1;
            logic s0, s1, p1;
            int g0, g1;
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            s0 = ($urandom_range(3) != 0);
            s1 = ($urandom_range(3) != 0);
            p1 = 1'($urandom);
            g0 = $urandom_range(40);
            g1 = $urandom_range(40);
            exp0.push_back('{d0, ~s0, 1'b0});
            exp1.push_back('{d1, ~s1, model_parity_err(d1, p1, 1'b0)});
            fork
                begin
                    repeat (g0) @(negedge clk);
                    send_frame(0, d0, s0, 1'b0, 1'b0);
                    drive_bit(0, 1'b1);
                end
                begin
                    repeat (g1) @(negedge clk);
                    send_frame(1, d1, s1, 1'b1, p1);
                    drive_bit(1, 1'b1);
                end
            join
        end
        tests_run++;
        if (got0.size() != exp0.size() || got1.size() != exp1.size()) begin
            tests_failed++;
            $display("[TB] FAIL random_count: got %0d/%0d frames expected %0d/%0d",
                     got0.size(), got1.size(), exp0.size(), exp1.size());
        end else begin
            for (int i = 0; i < exp0.size(); i++) begin
                tests_run++;
                if (got0[i] !== exp0[i]) begin
                    tests_failed++;
                    $display("[TB] FAIL random_dut0_%0d: got %h expected %h", i, got0[i], exp0[i]);
                end
                tests_run++;
                if (got1[i] !== exp1[i]) begin
                    tests_failed++;
                    $display("[TB] FAIL random_dut1_%0d: got %h expected %h", i, got1[i], exp1[i]);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        ready0 = 1'b1;
        got0.delete();
        // Make sure the holding register is non-zero before the reset hits.
        send_frame(0, 8'hC3, 1'b1, 1'b0, 1'b0);
        ready0 = 1'b0;
        drive_bit(0, 1'b1);
        got0.delete();
        fork
            send_frame(0, 8'hFF, 1'b1, 1'b0, 1'b0);
            begin
                @(negedge clk);
                repeat (5 * BIT_CLK + BIT_CLK / 2) @(negedge clk);
                reset_n = 1'b0;
                repeat (3) @(negedge clk);
                tests_run++;
                if ({data0, valid0, fe0, pe0, ovr0} !== 12'h000) begin
                    tests_failed++;
                    $display("[TB] FAIL midframe_reset: got %h expected 000", {data0, valid0, fe0, pe0, ovr0});
                end
                reset_n = 1'b1;
            end
        join
        ready0 = 1'b1;
        drive_bit(0, 1'b1);
        tests_run++;
        if (got0.size() != 0 || valid0 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midframe_abort: got %0d frames valid=%b expected 0 0", got0.size(), valid0);
        end
        send_frame(0, 8'h5A, 1'b1, 1'b0, 1'b0);
        drive_bit(0, 1'b1);
        tests_run++;
        if (got0.size() != 1) begin
            tests_failed++;
            $display("[TB] FAIL after_reset_count: got %0d frames expected 1", got0.size());
        end else begin
            tests_run++;
            if (got0[0] !== rx_item_t'{8'h5A, 1'b0, 1'b0}) begin
                tests_failed++;
                $display("[TB] FAIL after_reset_5a: got %h expected %h", got0[0], rx_item_t'{8'h5A, 1'b0, 1'b0});
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_glitch();
        test_break();
        test_parity();
        test_overrun();
        test_random();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
